// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer.
package ov7670_cfg_pkg;

   typedef enum logic [3:0] {
      S_PWR,
      S_PWR_REL,
      S_SRST,
      S_SRST_WAIT,
      S_FETCH,
      S_DECODE,
      S_DELAY,
      S_ISSUE,
      S_RUN,
      S_USR
   } cfg_state_t;

   localparam logic [15:0] ROM_END  = 16'hFFFF;
   localparam logic [15:0] ROM_DLY  = 16'hFFF0;
   localparam logic [7:0]  SRST_REG = 8'h12;
   localparam logic [7:0]  SRST_VAL = 8'h80;

endpackage

// File: rtl/cfg_wait_timer.sv
// One-shot cycle timer: start loads N, done pulses in the last of N busy cycles.
module cfg_wait_timer (
   input  logic        xclk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] n,
   output logic        done
);

   logic [31:0] count;
   logic [31:0] target;
   logic        busy;

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge xclk) begin
      if (!reset) begin
         busy   <= 1'b0;
         count  <= '0;
         target <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         count  <= '0;
         target <= (n == 32'd0) ? 32'd0 : n - 32'd1;
      end else if (busy) begin
         if (count == target) busy  <= 1'b0;
         else                 count <= count + 32'd1;
      end
   end

   // Combinational so the owner sees done in the final cycle and the pulse never repeats.
   assign done = busy && (count == target);

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Power-up, soft reset and ROM streaming into a single SCCB write engine, plus runtime user writes.
module ov7670_cfg_sequencer
   import ov7670_cfg_pkg::*;
#(
   parameter logic [7:0] DEV_ADDR      = 8'h42,
   parameter int         ROM_AW        = 8,
   parameter int         PWR_WAIT_CYC  = 25000,
   parameter int         SRST_WAIT_CYC = 25000,
   parameter int         DLY_CYC       = 250000,
   parameter int         MAX_RETRY     = 3
) (
   input  logic              xclk,
   input  logic              reset,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        tx_dev,
   output logic [7:0]        tx_reg,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   input  logic              tx_nack,
   input  logic              usr_req,
   input  logic [7:0]        usr_reg,
   input  logic [7:0]        usr_data,
   output logic              usr_ack,
   input  logic              restart_cfg,
   output logic              cam_pwdn,
   output logic              cam_rst_n,
   output logic              cfg_done,
   output logic              cfg_err
);

   localparam logic [ROM_AW-1:0] ROM_LAST  = {ROM_AW{1'b1}};
   localparam logic [7:0]        RETRY_LIM = 8'(MAX_RETRY);

   cfg_state_t  state;
   logic [7:0]  retry;
   logic        tmr_start;
   logic [31:0] tmr_n;
   logic        tmr_done;

   assign tx_dev = DEV_ADDR;

   cfg_wait_timer u_timer (
      .xclk  (xclk),
      .reset (reset),
      .start (tmr_start),
      .n     (tmr_n),
      .done  (tmr_done)
   );

   always_ff @(posedge xclk) begin
      if (!reset) begin
         state     <= S_PWR;
         rom_addr  <= '0;
         tx_valid  <= 1'b0;
         tx_reg    <= '0;
         tx_data   <= '0;
         retry     <= '0;
         usr_ack   <= 1'b0;
         cam_pwdn  <= 1'b1;
         cam_rst_n <= 1'b0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         // The power-up hold starts counting on the first edge out of reset.
         tmr_start <= 1'b1;
         tmr_n     <= 32'(PWR_WAIT_CYC);
      end else begin
         tmr_start <= 1'b0;
         usr_ack   <= 1'b0;
         case (state)
            S_PWR: if (tmr_done) begin
               cam_pwdn  <= 1'b0;
               cam_rst_n <= 1'b1;
               tmr_start <= 1'b1;
               tmr_n     <= 32'(PWR_WAIT_CYC);
               state     <= S_PWR_REL;
            end
            S_PWR_REL: if (tmr_done) begin
               tx_reg   <= SRST_REG;
               tx_data  <= SRST_VAL;
               tx_valid <= 1'b1;
               retry    <= '0;
               state    <= S_SRST;
            end
            S_SRST_WAIT: if (tmr_done) begin
               rom_addr <= '0;
               state    <= S_FETCH;
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               if (rom_data == ROM_END) begin
                  cfg_done <= 1'b1;
                  state    <= S_RUN;
               end else if (rom_data == ROM_DLY) begin
                  tmr_start <= 1'b1;
                  tmr_n     <= 32'(DLY_CYC);
                  state     <= S_DELAY;
               end else begin
                  tx_reg   <= rom_data[15:8];
                  tx_data  <= rom_data[7:0];
                  tx_valid <= 1'b1;
                  retry    <= '0;
                  state    <= S_ISSUE;
               end
            end
            S_DELAY: if (tmr_done) begin
               rom_addr <= rom_addr + 1'b1;
               state    <= S_FETCH;
            end
            S_RUN: begin
               if (restart_cfg) begin
                  rom_addr <= '0;
                  cfg_done <= 1'b0;
                  state    <= S_FETCH;
               end else if (usr_req && !usr_ack) begin
                  // usr_req is still high in the ack cycle; the !usr_ack guard stops a double issue.
                  tx_reg   <= usr_reg;
                  tx_data  <= usr_data;
                  tx_valid <= 1'b1;
                  retry    <= '0;
                  cfg_done <= 1'b0;
                  state    <= S_USR;
               end
            end
            S_SRST, S_ISSUE, S_USR: begin
               if (tx_valid) begin
                  if (tx_ready) tx_valid <= 1'b0;
               end else if (tx_done) begin
                  if (tx_nack && retry < RETRY_LIM) begin
                     retry    <= retry + 1'b1;
                     tx_valid <= 1'b1;
                  end else begin
                     if (tx_nack) cfg_err <= 1'b1;
                     case (state)
                        S_SRST: begin
                           tmr_start <= 1'b1;
                           tmr_n     <= 32'(SRST_WAIT_CYC);
                           state     <= S_SRST_WAIT;
                        end
                        S_ISSUE: begin
                           if (rom_addr == ROM_LAST) begin
                              cfg_done <= 1'b1;
                              state    <= S_RUN;
                           end else begin
                              rom_addr <= rom_addr + 1'b1;
                              state    <= S_FETCH;
                           end
                        end
                        default: begin
                           usr_ack  <= 1'b1;
                           cfg_done <= 1'b1;
                           state    <= S_RUN;
                        end
                     endcase
                  end
               end
            end
            default: state <= S_PWR;
         endcase
      end
   end

endmodule

// File: doc/ov7670_cfg_sequencer.md
Name: ov7670_cfg_sequencer

Overview:
- Top-level configuration scheduler for the OV7670 camera.
- After reset, runs the power-up sequence: PWDN and camera reset timing, then a soft-reset register write. It then streams register/value pairs from the config ROM into a single-transaction SCCB write engine.
- Once init is complete, it shares that engine with one runtime requester (user register writes) and supports re-running the full ROM on command.

Parameters:
- DEV_ADDR, 8'h42, SCCB write address placed on tx_dev for every transaction.
- ROM_AW, 8, config ROM address width; ROM holds 2**ROM_AW entries.
- PWR_WAIT_CYC, 25000, xclk cycles with cam_pwdn=1/cam_rst_n=0, then the same count again after release.
- SRST_WAIT_CYC, 25000, xclk cycles to wait after the soft-reset write (0x12=0x80).
- DLY_CYC, 250000, xclk cycles for a ROM delay marker.
- MAX_RETRY, 3, re-issues per transaction on NACK before giving up.

Ports:
- xclk, in, 1, system clock.
- reset, in, 1, synchronous, active-low reset.
- rom_addr, out, ROM_AW, config ROM read address (ROM has 1-cycle registered read).
- rom_data, in, 16, ROM word: [15:8] register, [7:0] value.
- tx_valid, out, 1, transaction request to the SCCB engine.
- tx_ready, in, 1, engine idle and able to accept.
- tx_dev, out, 8, device address (DEV_ADDR).
- tx_reg, out, 8, register address.
- tx_data, out, 8, register value.
- tx_done, in, 1, one-cycle pulse when the engine finishes a transaction.
- tx_nack, in, 1, valid with tx_done; 1 means the slave did not ACK.
- usr_req, in, 1, runtime write request; level, held until usr_ack.
- usr_reg, in, 8, runtime register address.
- usr_data, in, 8, runtime register value.
- usr_ack, out, 1, one-cycle pulse when the user transaction completes.
- restart_cfg, in, 1, pulse: re-run ROM from entry 0 (accepted only in S_RUN).
- cam_pwdn, out, 1, camera power-down pin.
- cam_rst_n, out, 1, camera hardware reset, active low.
- cfg_done, out, 1, high while in S_RUN.
- cfg_err, out, 1, sticky; set when any transaction exhausts its retries.

Behaviour:
- Reset (reset=0 at a xclk edge):
  - state=S_PWR, counters=0, rom_addr=0, tx_valid=0, usr_ack=0.
  - cam_pwdn=1, cam_rst_n=0, cfg_done=0, cfg_err=0.
  - Reset mid-transaction drops tx_valid on the next edge; any tx_done arriving afterwards is ignored.
- S_PWR: hold pins for PWR_WAIT_CYC, then set cam_pwdn=0, cam_rst_n=1 and wait PWR_WAIT_CYC more -> S_SRST.
- S_SRST: issue reg 0x12, data 0x80 -> on completion S_SRST_WAIT.
- S_SRST_WAIT: wait SRST_WAIT_CYC -> S_FETCH with rom_addr=0.
- S_FETCH: drive rom_addr and wait one cycle. S_DECODE then samples rom_data:
  - 16'hFFFF -> S_RUN (end marker).
  - 16'hFFF0 -> S_DELAY (delay marker).
  - anything else -> S_ISSUE.
- S_DELAY: wait DLY_CYC, increment rom_addr -> S_FETCH.
- ROM transaction completion:
  - On done without NACK, increment rom_addr.
  - If rom_addr was 2**ROM_AW-1 (last entry, no wrap) -> S_RUN; otherwise -> S_FETCH.
- Issue handshake, common to every transaction:
  - Assert tx_valid with tx_dev/reg/data held stable until the cycle where tx_valid & tx_ready; deassert the next cycle.
  - Then wait for tx_done.
  - If tx_nack: increment the retry counter and re-issue the same bytes while retries < MAX_RETRY.
  - Otherwise set cfg_err and treat the transaction as done (skip the entry).
  - The retry counter clears on every new transaction.
- S_RUN: cfg_done=1.
  - If restart_cfg: rom_addr=0, cfg_done=0 -> S_FETCH. Power-up and soft reset are not repeated.
  - Else if usr_req: latch usr_reg/usr_data -> S_USR, issued via the same handshake.
  - restart_cfg and usr_req in the same cycle: restart wins; usr_req stays pending and is served after the next S_RUN entry.
  - usr_req outside S_RUN is ignored (not acked) until S_RUN.
- S_USR completion: pulse usr_ack for 1 cycle (even if retries are exhausted; cfg_err records the failure) -> S_RUN. The requester must drop usr_req the cycle after usr_ack.
- tx_done while not waiting for one is ignored.
- Wait counters are 32-bit, count from 0 to N-1 inclusive, and a wait of N=0 is treated as 1 cycle.

Decomposition:
- Package ov7670_cfg_pkg holds:
  - the state enum;
  - ROM_END=16'hFFFF, ROM_DLY=16'hFFF0;
  - SRST_REG=8'h12, SRST_VAL=8'h80.
- One natural sub-module: cfg_wait_timer (load N, start, done pulse), reused for all waits.
- Retry/issue logic stays inline in the FSM.

Test Plan:
- PWR_WAIT_CYC=4, SRST_WAIT_CYC=4, engine model with 3-cycle tx_ready-low, no NACK:
  - cam_rst_n rises at cycle 4 after reset release.
  - First tx is reg 0x12/data 0x80.
  - Then ROM {0x1280? no: 0x3A04, 0x40D0, FFFF} yields exactly 2 more transactions; cfg_done=1 after the second.
- ROM {0x1101, FFF0, 0x6B4A, FFFF} with DLY_CYC=10 -> at least 10 idle cycles between tx_done of 0x11 and tx_valid of 0x6B.
- Engine NACKs reg 0x40 three times, then ACKs with MAX_RETRY=3 -> 4 issues of identical bytes, cfg_err=0.
- Engine NACKs every attempt -> 4 issues, then cfg_err=1 and the sequencer advances to the next entry.
- In S_RUN, usr_req with reg 0x71/data 0x80:
  - one tx with dev 0x42, reg 0x71, data 0x80, then one usr_ack pulse.
  - restart_cfg with usr_req in the same cycle -> ROM replays from 0 before the user tx.
- Assert reset (low) for 1 cycle while tx_valid=1 -> tx_valid=0, cam_pwdn=1 and cam_rst_n=0 on the next edge; a late tx_done is ignored.
